// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file definitions for the writeback slice.
//   XLEN        - datapath width
//   REG_ADDR_W  - register address width (32 architectural registers)
//   reg_addr_t  - register index type
//   wb_entry_t  - one buffered result: destination register plus data
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: small synchronous FIFO of writeback entries.
//   i_clk / i_rst   - clock, asynchronous active-low reset (clears pointers/count)
//   i_push          - write i_push_entry at the tail (ignored when full, unless popping)
//   i_pop           - drop the head entry (ignored when empty)
//   o_head          - current head entry, valid whenever o_empty is low
//   o_full/o_empty  - occupancy flags
// The head is read combinationally so the owner can commit it in the same
// cycle it is presented. A pushed entry becomes visible one cycle later.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_push,
  input  wb_entry_t i_push_entry,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  wb_entry_t mem [DEPTH];

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_head  = mem[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: stale contents are unreachable once count is zero.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr_q] <= i_push_entry;
  end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: write-side companion of the 32x32 register file.
//   i_clk / i_rst              - clock, asynchronous active-low reset
//   i_alu_*                    - single-cycle ALU result (always wins the write port)
//   i_lsu_* / o_lsu_ready      - LSU result stream, buffered in wb_fifo
//   i_issue_valid / i_issue_rd - load issue, marks destination pending
//   i_dec_rs1/rs2/rd           - decode register addresses
//   i_rs1/2_rf_data            - regfile read data
//   o_rs1/2_data               - operands with same-cycle commit bypass
//   o_stall                    - decode hold on load-use / WAW with pending load
//   o_rd_wren/addr/data        - regfile write port
module rf_writeback
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int XLEN       = rv_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [4:0]      i_lsu_rd,
  input  logic [XLEN-1:0] i_lsu_data,
  input  logic            i_issue_valid,
  input  logic [4:0]      i_issue_rd,
  input  logic [4:0]      i_dec_rs1,
  input  logic [4:0]      i_dec_rs2,
  input  logic [4:0]      i_dec_rd,
  input  logic [XLEN-1:0] i_rs1_rf_data,
  input  logic [XLEN-1:0] i_rs2_rf_data,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  output logic            o_stall,
  output logic            o_rd_wren,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data
);

  wb_entry_t fifo_head;
  wb_entry_t push_entry;
  logic      fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic      lsu_commit, commit;

  logic [NUM_REGS-1:0] busy_q, busy_d;

  assign push_entry = '{rd: i_lsu_rd, data: i_lsu_data};

  // The FIFO head only commits when the ALU is idle.
  assign lsu_commit = ~i_alu_valid & ~fifo_empty;
  assign fifo_pop   = lsu_commit;
  assign commit     = i_alu_valid | lsu_commit;

  assign o_lsu_ready = ~fifo_full | fifo_pop;
  assign fifo_push   = i_lsu_valid & o_lsu_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_push       (fifo_push),
    .i_push_entry (push_entry),
    .i_pop        (fifo_pop),
    .o_head       (fifo_head),
    .o_full       (fifo_full),
    .o_empty      (fifo_empty)
  );

  // Write port: a commit to x0 still selects (and pops) but never writes.
  always_comb begin
    o_rd_addr = '0;
    o_rd_data = '0;
    if (i_alu_valid) begin
      o_rd_addr = i_alu_rd;
      o_rd_data = i_alu_data;
    end else if (lsu_commit) begin
      o_rd_addr = fifo_head.rd;
      o_rd_data = fifo_head.data;
    end
    o_rd_wren = commit & (o_rd_addr != '0);
  end

  // Scoreboard: a new issue to the same register overrides the retiring load.
  always_comb begin
    busy_d = busy_q;
    if (lsu_commit) busy_d[fifo_head.rd] = 1'b0;
    if (i_issue_valid) busy_d[i_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Bypass: the committing value reaches decode in the same cycle it is written.
  always_comb begin
    o_rs1_data = i_rs1_rf_data;
    o_rs2_data = i_rs2_rf_data;
    if (o_rd_wren && o_rd_addr == i_dec_rs1) o_rs1_data = o_rd_data;
    if (o_rd_wren && o_rd_addr == i_dec_rs2) o_rs2_data = o_rd_data;
    if (i_dec_rs1 == '0) o_rs1_data = '0;
    if (i_dec_rs2 == '0) o_rs2_data = '0;
  end

  // A source waiting on a load is released in the cycle that load commits,
  // since the bypass supplies the value. The destination check is not
  // released early so a younger write cannot land before the load.
  logic hz_rs1, hz_rs2;
  assign hz_rs1  = busy_q[i_dec_rs1] & ~(lsu_commit && fifo_head.rd == i_dec_rs1);
  assign hz_rs2  = busy_q[i_dec_rs2] & ~(lsu_commit && fifo_head.rd == i_dec_rs2);
  assign o_stall = hz_rs1 | hz_rs2 | busy_q[i_dec_rd];

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_alu_valid;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_lsu_valid;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_rd;
  logic [31:0] i_lsu_data;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic [4:0]  i_dec_rs1, i_dec_rs2, i_dec_rd;
  logic [31:0] i_rs1_rf_data, i_rs2_rf_data;
  logic [31:0] o_rs1_data, o_rs2_data;
  logic        o_stall;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;

  rf_writeback #(.FIFO_DEPTH(2), .XLEN(32)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_alu_valid   (i_alu_valid),
    .i_alu_rd      (i_alu_rd),
    .i_alu_data    (i_alu_data),
    .i_lsu_valid   (i_lsu_valid),
    .o_lsu_ready   (o_lsu_ready),
    .i_lsu_rd      (i_lsu_rd),
    .i_lsu_data    (i_lsu_data),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_dec_rs1     (i_dec_rs1),
    .i_dec_rs2     (i_dec_rs2),
    .i_dec_rd      (i_dec_rd),
    .i_rs1_rf_data (i_rs1_rf_data),
    .i_rs2_rf_data (i_rs2_rf_data),
    .o_rs1_data    (o_rs1_data),
    .o_rs2_data    (o_rs2_data),
    .o_stall       (o_stall),
    .o_rd_wren     (o_rd_wren),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  localparam int DEPTH = 2;

  int tests = 0;
  int fails = 0;

  // Reference model: pending LSU results in arrival order, and the set of
  // registers with a load in flight.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t        q[$];
  logic [31:0] busy_m;
  logic        exp_ready_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    i_alu_valid   = 1'b0;
    i_alu_rd      = '0;
    i_alu_data    = '0;
    i_lsu_valid   = 1'b0;
    i_lsu_rd      = '0;
    i_lsu_data    = '0;
    i_issue_valid = 1'b0;
    i_issue_rd    = '0;
    i_dec_rs1     = '0;
    i_dec_rs2     = '0;
    i_dec_rd      = '0;
    i_rs1_rf_data = 32'hA5A5_0001;
    i_rs2_rf_data = 32'h5A5A_0002;
  endtask

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf,
                                          input logic wren, input logic [4:0] wa,
                                          input logic [31:0] wd);
    if (rs == 0) return 32'h0;
    if (wren && wa == rs) return wd;
    return rf;
  endfunction

  // Inputs were applied at the falling edge; check every output mid-cycle.
  task automatic eval(input string tag);
    logic        c_alu, c_lsu, e_wren, e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    #2;
    c_alu  = i_alu_valid;
    c_lsu  = !c_alu && (q.size() > 0);
    e_addr = c_alu ? i_alu_rd : (c_lsu ? q[0].rd : 5'd0);
    e_data = c_alu ? i_alu_data : (c_lsu ? q[0].data : 32'd0);
    e_wren = (c_alu || c_lsu) && (e_addr != 0);
    exp_ready_v = (q.size() < DEPTH) || c_lsu;
    e_stall = (busy_m[i_dec_rs1] && !(c_lsu && q[0].rd == i_dec_rs1)) ||
              (busy_m[i_dec_rs2] && !(c_lsu && q[0].rd == i_dec_rs2)) ||
              busy_m[i_dec_rd];
    chk({tag, ".wren"},  32'(o_rd_wren),   32'(e_wren));
    chk({tag, ".addr"},  32'(o_rd_addr),   32'(e_addr));
    chk({tag, ".data"},  o_rd_data,        e_data);
    chk({tag, ".ready"}, 32'(o_lsu_ready), 32'(exp_ready_v));
    chk({tag, ".stall"}, 32'(o_stall),     32'(e_stall));
    chk({tag, ".rs1"},   o_rs1_data, operand(i_dec_rs1, i_rs1_rf_data, e_wren, e_addr, e_data));
    chk({tag, ".rs2"},   o_rs2_data, operand(i_dec_rs2, i_rs2_rf_data, e_wren, e_addr, e_data));
    $display("[TB] %s wren=%0b addr=%0d data=%h ready=%0b stall=%0b rs1=%h rs2=%h",
             tag, o_rd_wren, o_rd_addr, o_rd_data, o_lsu_ready, o_stall, o_rs1_data, o_rs2_data);
  endtask

  // Advance the model across the rising edge, then return at the falling edge.
  task automatic tick();
    logic c_lsu;
    logic acc;
    c_lsu = !i_alu_valid && (q.size() > 0);
    acc   = i_lsu_valid && exp_ready_v;
    if (c_lsu) begin
      busy_m[q[0].rd] = 1'b0;
      void'(q.pop_front());
    end
    if (i_issue_valid && i_issue_rd != 0) busy_m[i_issue_rd] = 1'b1;
    busy_m[0] = 1'b0;
    if (acc) q.push_back('{rd: i_lsu_rd, data: i_lsu_data});
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rst = 1'b0;
    q.delete();
    busy_m = '0;
    #2;
    chk("rst.wren",  32'(o_rd_wren),   32'd0);
    chk("rst.addr",  32'(o_rd_addr),   32'd0);
    chk("rst.data",  o_rd_data,        32'd0);
    chk("rst.ready", 32'(o_lsu_ready), 32'd1);
    chk("rst.stall", 32'(o_stall),     32'd0);
    chk("rst.rs1",   o_rs1_data,       32'd0);
    $display("[TB] reset asserted wren=%0b ready=%0b stall=%0b", o_rd_wren, o_lsu_ready, o_stall);
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  initial begin
    int accepted;
    clear_inputs();
    i_rst  = 1'b1;
    busy_m = '0;
    @(negedge i_clk);
    do_reset();

    // ALU priority over a buffered load result
    clear_inputs();
    i_issue_valid = 1'b1; i_issue_rd = 5'd6;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd6; i_lsu_data = 32'h22;
    eval("prio_push");
    tick();
    clear_inputs();
    i_alu_valid = 1'b1; i_alu_rd = 5'd5; i_alu_data = 32'h11; i_dec_rs1 = 5'd6;
    eval("prio_alu");
    chk("prio_alu.x5", 32'(o_rd_addr), 32'd5);
    chk("prio_alu.d11", o_rd_data, 32'h11);
    tick();
    clear_inputs();
    i_dec_rs1 = 5'd6; i_rs1_rf_data = 32'h999;
    eval("prio_lsu");
    chk("prio_lsu.x6", 32'(o_rd_addr), 32'd6);
    chk("prio_lsu.byp", o_rs1_data, 32'h22);
    tick();
    clear_inputs();
    i_dec_rs2 = 5'd6; i_dec_rd = 5'd6;
    eval("prio_clear");
    chk("prio_clear.stall", 32'(o_stall), 32'd0);
    tick();

    // Load-use hazard on x7
    clear_inputs();
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    eval("lu_issue");
    tick();
    for (int k = 0; k < 2; k++) begin
      clear_inputs();
      i_dec_rs1 = 5'd7; i_rs1_rf_data = 32'h1234_5678;
      eval("lu_wait");
      chk("lu_wait.stall", 32'(o_stall), 32'd1);
      tick();
    end
    clear_inputs();
    i_dec_rs1 = 5'd7; i_lsu_valid = 1'b1; i_lsu_rd = 5'd7; i_lsu_data = 32'hDEAD;
    eval("lu_push");
    chk("lu_push.stall", 32'(o_stall), 32'd1);
    tick();
    clear_inputs();
    i_dec_rs1 = 5'd7; i_rs1_rf_data = 32'h1234_5678;
    eval("lu_commit");
    chk("lu_commit.stall", 32'(o_stall), 32'd0);
    chk("lu_commit.rs1", o_rs1_data, 32'hDEAD);
    tick();

    // FIFO fills while the ALU hogs the write port
    accepted = 0;
    for (int c = 0; c < 4; c++) begin
      clear_inputs();
      i_alu_valid = 1'b1; i_alu_rd = 5'(10 + c); i_alu_data = 32'(c);
      i_lsu_valid = (accepted < 3);
      i_lsu_rd = 5'(20 + accepted); i_lsu_data = 32'(256 + accepted);
      eval("full_fill");
      chk("full_fill.rdy", 32'(o_lsu_ready), (c < 2) ? 32'd1 : 32'd0);
      if (i_lsu_valid && exp_ready_v) accepted++;
      tick();
    end
    chk("full.accepted", 32'(accepted), 32'd2);
    for (int d = 0; d < 3; d++) begin
      clear_inputs();
      i_lsu_valid = (accepted < 3);
      i_lsu_rd = 5'(20 + accepted); i_lsu_data = 32'(256 + accepted);
      eval("full_drain");
      chk("full_drain.addr", 32'(o_rd_addr), 32'(20 + d));
      chk("full_drain.data", o_rd_data, 32'(256 + d));
      if (i_lsu_valid && exp_ready_v) accepted++;
      tick();
    end
    clear_inputs();
    eval("full_empty");
    chk("full_empty.wren", 32'(o_rd_wren), 32'd0);
    tick();

    // x0 destination and source
    clear_inputs();
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd0; i_lsu_data = 32'hFFFF;
    eval("x0_push");
    tick();
    clear_inputs();
    i_dec_rs1 = 5'd0; i_rs1_rf_data = 32'hABCD; i_issue_valid = 1'b1; i_issue_rd = 5'd0;
    eval("x0_commit");
    chk("x0_commit.wren", 32'(o_rd_wren), 32'd0);
    chk("x0_commit.rs1", o_rs1_data, 32'd0);
    tick();
    clear_inputs();
    eval("x0_after");
    chk("x0_after.data", o_rd_data, 32'd0);
    chk("x0_after.stall", 32'(o_stall), 32'd0);
    tick();

    // Set/clear collision on x9
    clear_inputs();
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    i_lsu_valid = 1'b1; i_lsu_rd = 5'd9; i_lsu_data = 32'h99;
    eval("col_push");
    tick();
    clear_inputs();
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    eval("col_both");
    chk("col_both.addr", 32'(o_rd_addr), 32'd9);
    tick();
    clear_inputs();
    i_dec_rs2 = 5'd9;
    eval("col_after");
    chk("col_after.stall", 32'(o_stall), 32'd1);
    tick();

    // Reset with two buffered entries and pending loads
    for (int k = 0; k < 2; k++) begin
      clear_inputs();
      i_alu_valid = 1'b1; i_alu_rd = 5'd1; i_alu_data = 32'(k);
      i_lsu_valid = 1'b1; i_lsu_rd = 5'(3 + k); i_lsu_data = 32'(k + 64);
      i_issue_valid = 1'b1; i_issue_rd = 5'(3 + k);
      eval("mid_fill");
      tick();
    end
    do_reset();
    for (int r = 0; r < 32; r++) begin
      clear_inputs();
      i_dec_rs1 = 5'(r); i_dec_rs2 = 5'(r); i_dec_rd = 5'(r);
      eval("post_rst");
      tick();
    end

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      clear_inputs();
      i_alu_valid   = ($urandom_range(0, 2) == 0);
      i_alu_rd      = 5'($urandom_range(0, 15));
      i_alu_data    = $urandom;
      i_lsu_valid   = ($urandom_range(0, 1) == 1);
      i_lsu_rd      = 5'($urandom_range(0, 15));
      i_lsu_data    = $urandom;
      i_issue_valid = ($urandom_range(0, 3) == 0);
      i_issue_rd    = 5'($urandom_range(0, 15));
      i_dec_rs1     = 5'($urandom_range(0, 15));
      i_dec_rs2     = 5'($urandom_range(0, 15));
      i_dec_rd      = 5'($urandom_range(0, 15));
      i_rs1_rf_data = $urandom;
      i_rs2_rf_data = $urandom;
      eval("rand");
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
- Write-side companion of the 32x32 register file. Owns the register file's write port (rd address, data, write enable).
- Arbitrates between two result sources: the single-cycle ALU path and the long-latency load/store unit (LSU). LSU results are buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard. Bypasses the committing result onto both read ports in the same cycle. Raises a decode stall on load-use hazards.

Parameters:
- FIFO_DEPTH, 2, number of LSU result entries; power of two, >=2
- XLEN, 32, data width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous active-low reset
- i_alu_valid  in  1  ALU result present this cycle (no backpressure)
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  XLEN  ALU result
- i_lsu_valid  in  1  LSU result offered
- o_lsu_ready  out  1  LSU result accepted when valid&ready
- i_lsu_rd  in  5  LSU destination register
- i_lsu_data  in  XLEN  LSU result
- i_issue_valid  in  1  load issued this cycle; marks i_issue_rd pending
- i_issue_rd  in  5  load destination
- i_dec_rs1  in  5  decode source 1 address (also drives regfile read port)
- i_dec_rs2  in  5  decode source 2 address
- i_dec_rd  in  5  decode destination
- i_rs1_rf_data  in  XLEN  regfile read data, port 1
- i_rs2_rf_data  in  XLEN  regfile read data, port 2
- o_rs1_data  out  XLEN  bypassed operand 1
- o_rs2_data  out  XLEN  bypassed operand 2
- o_stall  out  1  hold decode this cycle
- o_rd_wren  out  1  regfile write enable
- o_rd_addr  out  5  regfile write address
- o_rd_data  out  XLEN  regfile write data

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active-low (i_rst=0).
- Reset effect: clears FIFO pointers and count and the 32-bit busy mask. o_lsu_ready=1, o_stall=0, o_rd_wren=0, o_rd_addr=0, o_rd_data=0. Bypass outputs pass regfile data.
- Reset mid-operation: buffered LSU results are discarded; the busy mask is cleared.
- Commit selection (combinational, zero latency):
  - i_alu_valid=1: the ALU result commits. ALU always has priority.
  - Otherwise, FIFO non-empty: the FIFO head commits and is popped at the clock edge.
  - Otherwise: no commit.
- x0 handling: o_rd_wren = commit & (addr != 0). A commit to x0 still pops its FIFO entry.
- o_rd_addr/o_rd_data carry the selected source and are 0 when there is no commit.
- FIFO push: on i_lsu_valid & o_lsu_ready.
  - o_lsu_ready = !full, or = 1 when full and a pop occurs this cycle (same-cycle push and pop allowed).
  - Push into an empty FIFO is not bypassed to commit: the entry appears at the head the next cycle (1-cycle minimum LSU latency).
- Pointers: wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- Busy mask:
  - Set busy[i_issue_rd] on i_issue_valid (rd != 0).
  - Clear busy[addr] when an LSU entry commits.
  - Same register set and cleared in the same cycle: set wins.
  - busy[0] is always 0.
- Bypass: if o_rd_wren and o_rd_addr == i_dec_rsN (N != 0), then o_rsN_data = o_rd_data. Otherwise o_rsN_data = i_rsN_rf_data. Source address 0 always yields 0.
- Stall: o_stall = hz(rs1) | hz(rs2) | busy[i_dec_rd].
  - hz(r) = busy[r] & !(LSU commit this cycle to r).
  - The busy[i_dec_rd] term prevents write-after-write overtaking a pending load.
- ALU commit to a busy register cannot occur while the stall protocol is obeyed. If it does occur, the write proceeds and busy is unchanged.

Decomposition:
- Shared package rv_pkg: XLEN, REG_ADDR_W=5, NUM_REGS=32, typedef reg_addr_t, typedef wb_entry_t {rd, data}.
- Sub-module wb_fifo (parameterised sync FIFO of wb_entry_t, push/pop/full/empty, async active-low reset).
- Arbiter, scoreboard and bypass stay in the top module.

Test Plan:
- Reset: i_rst low mid-stream with 2 FIFO entries -> after release, o_rd_wren=0, o_lsu_ready=1, o_stall=0, FIFO empty, all busy bits 0.
- ALU priority: ALU (x5, 0x11) and FIFO head (x6, 0x22) present together -> x5 written first. Next cycle with ALU idle -> x6=0x22 written, then busy[6] clears.
- Load-use: issue load to x7, decode rs1=x7 -> o_stall=1 each cycle until the LSU commit of x7 (0xDEAD). In that cycle o_stall=0 and o_rs1_data=0xDEAD, regardless of i_rs1_rf_data.
- FIFO full: ALU valid for 4 cycles while LSU offers 3 results -> o_lsu_ready drops after 2 pushes. Entries then drain in order with no loss or duplication.
- x0: LSU result to x0 with data 0xFFFF -> o_rd_wren=0, entry popped. Decode rs1=x0 -> o_rs1_data=0, never stalls.
- Set/clear collision: LSU commits x9 while a new load to x9 is issued the same cycle -> busy[9] remains 1 and decode rs2=x9 next cycle stalls.
